// File: rtl/seq_pkg.sv
// Shared opcode, state and decode-bundle definitions for the ALU control sequencer.
package seq_pkg;

  localparam int unsigned PC_W_DEFAULT = 10;

  // Opcodes reuse the ALU command encodings so ALU ops can forward op directly.
  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_LSL   = 4'b0001,
    OP_LSR   = 4'b0010,
    OP_MOV   = 4'b0011,
    OP_OR    = 4'b0100,
    OP_XOR   = 4'b0101,
    OP_AND   = 4'b0110,
    OP_ADDI  = 4'b0111,
    OP_BNE   = 4'b1000,
    OP_BEQ   = 4'b1001,
    OP_MOVI  = 4'b1010,
    OP_LOAD  = 4'b1011,
    OP_STORE = 4'b1100,
    OP_CMP   = 4'b1101,
    OP_HALT  = 4'b1110,
    OP_NOP   = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXEC     = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0] alu_cmd;
    logic [2:0] ra_addr;
    logic [2:0] rb_addr;
    logic [2:0] wr_addr;
    logic       reg_we;
    logic [7:0] imm;
    logic       use_imm;
    logic       sc_i;
    logic [4:0] lut_idx;
    logic       carry_upd;
    logic       eq_upd;
    logic       branch;
    logic       branch_eq;
    logic       mem_op;
    logic       store;
    logic       halt;
  } dec_t;

endpackage

// File: rtl/seq_decode.sv
// Combinational instruction decode: opcode and fields to ALU command and strobes.
module seq_decode
  import seq_pkg::*;
(
  input  logic [8:0] instr,
  input  logic       carry_q,
  output dec_t       dec
);

  opcode_e op;

  always_comb begin
    op          = opcode_e'(instr[8:5]);
    dec         = '0;
    dec.alu_cmd = OP_NOP;
    dec.ra_addr = instr[4:2];
    dec.rb_addr = {1'b0, instr[1:0]};
    case (op)
      OP_ADD, OP_LSL, OP_LSR: begin
        dec.alu_cmd   = instr[8:5];
        dec.sc_i      = carry_q;
        dec.reg_we    = 1'b1;
        dec.wr_addr   = instr[4:2];
        dec.carry_upd = 1'b1;
      end
      OP_MOV, OP_OR, OP_XOR, OP_AND: begin
        dec.alu_cmd = instr[8:5];
        dec.reg_we  = 1'b1;
        dec.wr_addr = instr[4:2];
      end
      OP_ADDI: begin
        dec.alu_cmd   = instr[8:5];
        dec.ra_addr   = '0;
        dec.use_imm   = 1'b1;
        dec.imm       = {3'b000, instr[4:0]};
        dec.reg_we    = 1'b1;
        dec.carry_upd = 1'b1;
      end
      OP_MOVI: begin
        dec.alu_cmd = instr[8:5];
        dec.use_imm = 1'b1;
        dec.imm     = {3'b000, instr[4:0]};
        dec.reg_we  = 1'b1;
      end
      OP_CMP: begin
        dec.alu_cmd = instr[8:5];
        dec.eq_upd  = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec.alu_cmd   = instr[8:5];
        dec.ra_addr   = 3'd0;
        dec.rb_addr   = 3'd1;
        dec.lut_idx   = instr[4:0];
        dec.branch    = 1'b1;
        dec.branch_eq = (op == OP_BEQ);
      end
      OP_LOAD:  dec.mem_op = 1'b1;
      OP_STORE: begin
        dec.mem_op = 1'b1;
        dec.store  = 1'b1;
      end
      OP_HALT:  dec.halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer: fetch by pc, drive ALU/regfile/memory strobes, hold carry/eq flags.
module alu_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  output logic            done,
  output logic [PC_W-1:0] pc,
  input  logic [8:0]      instr,
  output logic [3:0]      alu_cmd,
  output logic            sc_i,
  input  logic            alu_sc_o,
  input  logic            alu_equal,
  output logic [2:0]      ra_addr,
  output logic [2:0]      rb_addr,
  output logic [2:0]      wr_addr,
  output logic            reg_we,
  output logic [7:0]      imm,
  output logic            use_imm,
  output logic [4:0]      lut_idx,
  input  logic [PC_W-1:0] lut_target,
  output logic            mem_req,
  output logic            mem_we,
  input  logic            mem_ack,
  output logic            carry_q,
  output logic            eq_flag
);

  state_e          state;
  dec_t            dec;
  logic [2:0]      mem_ra;
  logic [1:0]      mem_rb;
  logic            mem_store;
  logic [PC_W-1:0] pc_inc;
  logic            br_taken;

  seq_decode u_decode (
    .instr   (instr),
    .carry_q (carry_q),
    .dec     (dec)
  );

  assign pc_inc   = pc + {{(PC_W-1){1'b0}}, 1'b1};
  assign br_taken = dec.branch && (alu_equal == dec.branch_eq);
  assign done     = (state == ST_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      pc        <= '0;
      carry_q   <= 1'b0;
      eq_flag   <= 1'b0;
      mem_ra    <= '0;
      mem_rb    <= '0;
      mem_store <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (req) begin
          state   <= ST_EXEC;
          pc      <= '0;
          carry_q <= 1'b0;
          eq_flag <= 1'b0;
        end
        ST_EXEC: begin
          if (dec.carry_upd) carry_q <= alu_sc_o;
          if (dec.eq_upd)    eq_flag <= alu_equal;
          if (dec.mem_op) begin
            // Fields are latched so MEM_WAIT does not depend on instr staying stable.
            state     <= ST_MEM_WAIT;
            mem_ra    <= instr[4:2];
            mem_rb    <= instr[1:0];
            mem_store <= dec.store;
          end else if (dec.halt) begin
            state <= ST_DONE;
          end else if (br_taken) begin
            pc <= lut_target;
          end else begin
            pc <= pc_inc;
          end
        end
        ST_MEM_WAIT: if (mem_ack) begin
          pc    <= pc_inc;
          state <= ST_EXEC;
        end
        ST_DONE: if (!req) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    alu_cmd = OP_NOP;
    sc_i    = 1'b0;
    ra_addr = '0;
    rb_addr = '0;
    wr_addr = '0;
    reg_we  = 1'b0;
    imm     = '0;
    use_imm = 1'b0;
    lut_idx = '0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    case (state)
      ST_EXEC: begin
        alu_cmd = dec.alu_cmd;
        sc_i    = dec.sc_i;
        ra_addr = dec.ra_addr;
        rb_addr = dec.rb_addr;
        wr_addr = dec.wr_addr;
        reg_we  = dec.reg_we;
        imm     = dec.imm;
        use_imm = dec.use_imm;
        lut_idx = dec.lut_idx;
      end
      ST_MEM_WAIT: begin
        mem_req = 1'b1;
        mem_we  = mem_store;
        ra_addr = mem_ra;
        rb_addr = {1'b0, mem_rb};
        wr_addr = mem_ra;
        reg_we  = mem_ack && !mem_store;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed scenarios plus randomized run against a behavioural model.
module tb_alu_sequencer;

  localparam int PCW    = 10;
  localparam int PC_MOD = 1 << PCW;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           req = 1'b0;
  logic           done;
  logic [PCW-1:0] pc;
  logic [8:0]     instr = '0;
  logic [3:0]     alu_cmd;
  logic           sc_i;
  logic           alu_sc_o = 1'b0;
  logic           alu_equal = 1'b0;
  logic [2:0]     ra_addr, rb_addr, wr_addr;
  logic           reg_we;
  logic [7:0]     imm;
  logic           use_imm;
  logic [4:0]     lut_idx;
  logic [PCW-1:0] lut_target = '0;
  logic           mem_req, mem_we;
  logic           mem_ack = 1'b0;
  logic           carry_q, eq_flag;

  always #5 clk = ~clk;

  alu_sequencer #(.PC_W(PCW)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done), .pc(pc), .instr(instr),
    .alu_cmd(alu_cmd), .sc_i(sc_i), .alu_sc_o(alu_sc_o), .alu_equal(alu_equal),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .wr_addr(wr_addr), .reg_we(reg_we),
    .imm(imm), .use_imm(use_imm), .lut_idx(lut_idx), .lut_target(lut_target),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
    .carry_q(carry_q), .eq_flag(eq_flag)
  );

  int checks = 0;
  int failures = 0;

  // Model: mode 0 idle, 1 executing, 2 waiting on memory, 3 halted.
  int mode, m_pc, m_ra;
  bit m_c, m_z, m_store;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mode = 0; m_pc = 0; m_c = 0; m_z = 0; m_ra = 0; m_store = 0;
  endtask

  task automatic post();
    @(posedge clk);
    #1;
  endtask

  // One cycle: drive inputs after the falling edge, compare outputs to the model, advance the model.
  task automatic step(input bit r, input logic [8:0] ins, input bit sc, input bit eqv,
                      input int tgt, input bit ack);
    int op, ra, rb, imm5;
    int e_cmd, e_sc, e_we, e_wr, e_ui, e_imm, e_lut, e_mreq, e_mwe, e_ra, e_rb;
    bit c_ra, c_rb, c_lut;
    @(negedge clk);
    req = r; instr = ins; alu_sc_o = sc; alu_equal = eqv;
    lut_target = tgt[PCW-1:0]; mem_ack = ack;
    #1;
    op = int'(ins[8:5]); ra = int'(ins[4:2]); rb = int'(ins[1:0]); imm5 = int'(ins[4:0]);
    e_cmd = 15; e_sc = 0; e_we = 0; e_wr = 0; e_ui = 0; e_imm = 0; e_lut = 0;
    e_mreq = 0; e_mwe = 0; e_ra = 0; e_rb = 0; c_ra = 0; c_rb = 0; c_lut = 0;
    if (mode == 1) begin
      if (op <= 6 || op == 13 || op == 11 || op == 12) begin
        c_ra = 1; c_rb = 1; e_ra = ra; e_rb = rb;
      end
      if (op <= 6 || op == 13) e_cmd = op;
      if (op <= 2) e_sc = m_c;
      if (op <= 6) begin e_we = 1; e_wr = ra; end
      if (op == 7 || op == 10) begin e_cmd = op; e_ui = 1; e_imm = imm5; e_we = 1; e_wr = 0; end
      if (op == 7) begin c_ra = 1; e_ra = 0; end
      if (op == 8 || op == 9) begin
        e_cmd = op; c_ra = 1; c_rb = 1; e_ra = 0; e_rb = 1; c_lut = 1; e_lut = imm5;
      end
    end else if (mode == 2) begin
      e_mreq = 1; e_mwe = m_store; c_ra = 1; e_ra = m_ra;
      if (ack && !m_store) begin e_we = 1; e_wr = m_ra; end
    end
    chk("alu_cmd", int'(alu_cmd), e_cmd);
    chk("sc_i", int'(sc_i), e_sc);
    chk("reg_we", int'(reg_we), e_we);
    if (e_we != 0) chk("wr_addr", int'(wr_addr), e_wr);
    chk("use_imm", int'(use_imm), e_ui);
    if (e_ui != 0) chk("imm", int'(imm), e_imm);
    if (c_lut) chk("lut_idx", int'(lut_idx), e_lut);
    if (c_ra) chk("ra_addr", int'(ra_addr), e_ra);
    if (c_rb) chk("rb_addr", int'(rb_addr), e_rb);
    chk("mem_req", int'(mem_req), e_mreq);
    if (e_mreq != 0) chk("mem_we", int'(mem_we), e_mwe);
    chk("done", int'(done), (mode == 3) ? 1 : 0);
    chk("pc", int'(pc), m_pc);
    chk("carry_q", int'(carry_q), int'(m_c));
    chk("eq_flag", int'(eq_flag), int'(m_z));
    case (mode)
      0: if (r) begin mode = 1; m_pc = 0; m_c = 0; m_z = 0; end
      1: begin
        if (op <= 2 || op == 7) m_c = sc;
        if (op == 13) m_z = eqv;
        if (op == 11 || op == 12) begin mode = 2; m_ra = ra; m_store = (op == 12); end
        else if (op == 14) mode = 3;
        else if ((op == 9 && eqv) || (op == 8 && !eqv)) m_pc = tgt % PC_MOD;
        else m_pc = (m_pc + 1) % PC_MOD;
      end
      2: if (ack) begin m_pc = (m_pc + 1) % PC_MOD; mode = 1; end
      default: if (!r) mode = 0;
    endcase
  endtask

  localparam logic [8:0] I_NOP = 9'b1111_00000;

  initial begin
    logic [8:0] ins;
    model_reset();
    #12;
    chk("rst_done", int'(done), 0);
    chk("rst_pc", int'(pc), 0);
    chk("rst_reg_we", int'(reg_we), 0);
    chk("rst_mem_req", int'(mem_req), 0);
    chk("rst_alu_cmd", int'(alu_cmd), 15);
    chk("rst_carry", int'(carry_q), 0);
    chk("rst_eq", int'(eq_flag), 0);
    @(negedge clk);
    reset = 1'b0;

    // Start, then movi 5
    step(1, I_NOP, 0, 0, 0, 0);
    step(0, 9'b1010_00101, 0, 0, 0, 0);
    chk("movi_reg_we", int'(reg_we), 1);
    chk("movi_wr_addr", int'(wr_addr), 0);
    chk("movi_imm", int'(imm), 5);
    post();
    chk("movi_pc", int'(pc), 1);

    // Carry chain: add sets carry, next add consumes it, addi ignores it
    step(0, 9'b0000_001_01, 1, 0, 0, 0);
    step(0, 9'b0000_010_10, 0, 0, 0, 0);
    chk("add_sc_i", int'(sc_i), 1);
    step(0, 9'b0111_00011, 0, 0, 0, 0);
    chk("addi_sc_i", int'(sc_i), 0);

    // cmp then beq taken, cmp then bne not taken
    step(0, 9'b1101_001_10, 0, 1, 0, 0);
    step(0, 9'b1001_00011, 0, 1, 'h2A, 0);
    post();
    chk("beq_pc", int'(pc), 'h2A);
    chk("cmp_eq_flag", int'(eq_flag), 1);
    step(0, 9'b1101_001_10, 0, 1, 0, 0);
    step(0, 9'b1000_00011, 0, 1, 'h2A, 0);
    post();
    chk("bne_pc", int'(pc), 'h2C);

    // Load with ack in the third wait cycle
    step(0, 9'b1011_010_01, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, I_NOP, 0, 0, 0, (k == 2));
      chk("load_mem_req", int'(mem_req), 1);
      if (k == 2) begin
        chk("load_reg_we", int'(reg_we), 1);
        chk("load_wr_addr", int'(wr_addr), 2);
      end
    end
    post();
    chk("load_pc", int'(pc), 'h2D);
    step(0, I_NOP, 0, 0, 0, 0);
    chk("load_mem_req_off", int'(mem_req), 0);

    // pc wrap
    step(0, 9'b1001_00000, 0, 1, 'h3FF, 0);
    post();
    chk("wrap_pre_pc", int'(pc), 'h3FF);
    step(0, I_NOP, 0, 0, 0, 0);
    post();
    chk("wrap_pc", int'(pc), 0);

    // Halt, hold while req high, release to idle
    step(0, I_NOP, 0, 0, 0, 0);
    step(1, 9'b1110_00000, 0, 0, 0, 0);
    post();
    chk("halt_done", int'(done), 1);
    chk("halt_pc", int'(pc), 1);
    step(1, I_NOP, 0, 0, 0, 0);
    step(0, I_NOP, 0, 0, 0, 0);
    post();
    chk("idle_done", int'(done), 0);

    // Asynchronous reset while waiting on a store
    step(1, I_NOP, 0, 0, 0, 0);
    step(0, I_NOP, 0, 0, 0, 0);
    step(0, I_NOP, 0, 0, 0, 0);
    step(0, 9'b1100_011_10, 0, 0, 0, 0);
    step(0, I_NOP, 0, 0, 0, 0);
    chk("store_mem_we", int'(mem_we), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_mem_req", int'(mem_req), 0);
    chk("arst_pc", int'(pc), 0);
    chk("arst_alu_cmd", int'(alu_cmd), 15);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Randomized run
    for (int n = 0; n < 3000; n++) begin
      ins = 9'($urandom);
      if (ins[8:5] == 4'b1110 && $urandom_range(0, 7) != 0) ins[8:5] = 4'b1111;
      step(bit'($urandom_range(0, 1)), ins, bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 1)), int'($urandom_range(0, PC_MOD - 1)),
           ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
